// File: rtl/streamer_pkg.sv
// rtl/streamer_pkg.sv - shared state type and constants for conv_input_streamer
package streamer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } streamer_state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic STREAM_A = 1'b0;
    localparam logic STREAM_B = 1'b1;

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry FIFO buffering one operand stream
module stream_fifo2
    import streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [FIFO_CNT_W-1:0] count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  rd_q;
    logic                  wr_q;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            count <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= push_data;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            count <= count + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
        end
    end

    assign head = mem_q[rd_q];

endmodule

// File: rtl/conv_input_streamer.sv
// rtl/conv_input_streamer.sv - memory-to-stream feeder for a/b operands; CONV_INPUT_STREAMER_STALL_CNT_EN adds stall_cycles
module conv_input_streamer
    import streamer_pkg::*;
#(
    parameter int IO_DATA_WIDTH  = 16,
    parameter int EXT_MEM_WIDTH  = 32,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_in,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] a_base,
    input  logic [MEM_ADDR_WIDTH-1:0] b_base,
    input  logic [LEN_WIDTH-1:0]      a_len,
    input  logic [LEN_WIDTH-1:0]      b_len,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_re,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [EXT_MEM_WIDTH-1:0]  mem_rdata,
    output logic [IO_DATA_WIDTH-1:0]  a_input,
    output logic [IO_DATA_WIDTH-1:0]  b_input,
    output logic                      a_valid,
    output logic                      b_valid,
    input  logic                      a_ready,
    input  logic                      b_ready
`ifdef CONV_INPUT_STREAMER_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    streamer_state_t state_q, state_d;

    logic [MEM_ADDR_WIDTH-1:0] base_q   [2];
    logic [LEN_WIDTH-1:0]      len_q    [2];
    logic [LEN_WIDTH-1:0]      issued_q [2];
    logic [1:0]                inflight_q;
    logic                      ptr_q;

    logic [FIFO_CNT_W-1:0]     fifo_count [2];
    logic [IO_DATA_WIDTH-1:0]  fifo_head  [2];
    logic [1:0]                valid, ready, pop, eligible, drained, grant;

    logic unused_rdata_hi;
    assign unused_rdata_hi = ^mem_rdata[EXT_MEM_WIDTH-1:IO_DATA_WIDTH];

    assign ready = {b_ready, a_ready};

    for (genvar s = 0; s < 2; s++) begin : g_stream
        assign valid[s] = (fifo_count[s] != '0);
        assign pop[s]   = valid[s] & ready[s];
        // A same-cycle pop frees a slot, which keeps a single stream at full rate.
        assign eligible[s] = (state_q == RUN) && (issued_q[s] < len_q[s]) &&
                             ({1'b0, fifo_count[s]} + {2'b00, inflight_q[s]}
                              < 3'd2 + {2'b00, pop[s]});
        assign drained[s]  = (issued_q[s] == len_q[s]) && !inflight_q[s] &&
                             (fifo_count[s] == FIFO_CNT_W'(pop[s]));

        stream_fifo2 #(
            .DATA_WIDTH(IO_DATA_WIDTH)
        ) u_fifo (
            .clk      (clk),
            .rst_in   (rst_in),
            .push     (inflight_q[s]),
            .push_data(mem_rdata[IO_DATA_WIDTH-1:0]),
            .pop      (pop[s]),
            .count    (fifo_count[s]),
            .head     (fifo_head[s])
        );
    end

    always_comb begin
        grant = 2'b00;
        if (eligible == 2'b11) begin
            grant = (ptr_q == STREAM_B) ? 2'b10 : 2'b01;
        end else begin
            grant = eligible;
        end
    end

    always_comb begin
        mem_addr = '0;
        if (grant[STREAM_A]) begin
            mem_addr = base_q[STREAM_A] + MEM_ADDR_WIDTH'(issued_q[STREAM_A]);
        end else if (grant[STREAM_B]) begin
            mem_addr = base_q[STREAM_B] + MEM_ADDR_WIDTH'(issued_q[STREAM_B]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (&drained) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q    <= IDLE;
            ptr_q      <= STREAM_A;
            inflight_q <= 2'b00;
            for (int s = 0; s < 2; s++) begin
                base_q[s]   <= '0;
                len_q[s]    <= '0;
                issued_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                base_q[STREAM_A]   <= a_base;
                base_q[STREAM_B]   <= b_base;
                len_q[STREAM_A]    <= a_len;
                len_q[STREAM_B]    <= b_len;
                issued_q[STREAM_A] <= '0;
                issued_q[STREAM_B] <= '0;
                inflight_q         <= 2'b00;
                ptr_q              <= STREAM_A;
            end else begin
                inflight_q <= grant;
                for (int s = 0; s < 2; s++) begin
                    if (grant[s]) issued_q[s] <= issued_q[s] + 1'b1;
                end
                if (eligible == 2'b11) ptr_q <= ~ptr_q;
            end
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign mem_re  = |grant;
    assign a_input = fifo_head[STREAM_A];
    assign b_input = fifo_head[STREAM_B];
    assign a_valid = valid[STREAM_A];
    assign b_valid = valid[STREAM_B];

`ifdef CONV_INPUT_STREAMER_STALL_CNT_EN
    logic stall_event;
    assign stall_event = (a_valid && !a_ready) || (b_valid && !b_ready);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            stall_cycles <= '0;
        end else if (state_q == IDLE && start) begin
            stall_cycles <= '0;
        end else if (state_q == RUN && stall_event && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_input_streamer.sv
// tb/tb_conv_input_streamer.sv - scoreboard bench for conv_input_streamer
module tb_conv_input_streamer;

    localparam int DW = 16;
    localparam int MW = 32;
    localparam int AW = 16;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_in = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] a_base = '0, b_base = '0;
    logic [LW-1:0] a_len = '0, b_len = '0;
    logic          busy, done, mem_re;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_rdata = '0;
    logic [DW-1:0] a_input, b_input;
    logic          a_valid, b_valid;
    logic          a_ready = 1'b1, b_ready = 1'b1;
`ifdef CONV_INPUT_STREAMER_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    conv_input_streamer dut (
        .clk      (clk),
        .rst_in   (rst_in),
        .start    (start),
        .a_base   (a_base),
        .b_base   (b_base),
        .a_len    (a_len),
        .b_len    (b_len),
        .busy     (busy),
        .done     (done),
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .a_input  (a_input),
        .b_input  (b_input),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .a_ready  (a_ready),
        .b_ready  (b_ready)
`ifdef CONV_INPUT_STREAMER_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = -1000;
    int mrel;
    int ready_mode = 0;

    logic [MW-1:0] mem [65536];
    logic [DW-1:0] exp_a [$];
    logic [DW-1:0] exp_b [$];
    int            rd_rel [$];
    int            rd_s [$];

    logic [AW-1:0] cur_a_base, cur_b_base;
    int            cur_a_len, cur_b_len;
    int            reads_a, reads_b, hs_a, hs_b;
    int            done_cnt, done_rel, busy_cnt, first_hs_rel, last_hs_rel;
    bit            b_valid_seen, mon_en = 1'b0;
    bit            a_stall_prev, b_stall_prev;
    logic [DW-1:0] a_prev, b_prev;
    logic [AW-1:0] ab, bb;
    int            al, bl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory with one cycle of read latency; idle cycles return noise.
    initial begin
        logic          pend;
        logic [AW-1:0] raddr;
        forever begin
            @(negedge clk);
            pend  = mem_re;
            raddr = mem_addr;
            @(posedge clk);
            #1;
            mem_rdata = pend ? mem[raddr] : $urandom;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    a_ready = ($urandom_range(0, 9) < 7);
                    b_ready = ($urandom_range(0, 9) < 7);
                end
                2: begin
                    a_ready = !((cyc - c0) >= 4 && (cyc - c0) <= 8);
                    b_ready = 1'b1;
                end
                default: begin
                    a_ready = 1'b1;
                    b_ready = 1'b1;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            mrel = cyc - c0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_rel = mrel;
                chk("busy_low_at_done", busy, 0);
            end
            if (b_valid) b_valid_seen = 1'b1;
            if (a_stall_prev) begin
                chk("a_hold_valid", a_valid, 1);
                chk("a_hold_data", a_input, a_prev);
            end
            if (b_stall_prev) begin
                chk("b_hold_valid", b_valid, 1);
                chk("b_hold_data", b_input, b_prev);
            end
            a_stall_prev = a_valid && !a_ready;
            b_stall_prev = b_valid && !b_ready;
            a_prev = a_input;
            b_prev = b_input;
            if (a_valid && a_ready) begin
                if (exp_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_extra: actual %0h required none", a_input);
                end else chk("a_data", a_input, exp_a.pop_front());
                hs_a++;
                if (first_hs_rel < 0) first_hs_rel = mrel;
                last_hs_rel = mrel;
            end
            if (b_valid && b_ready) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_extra: actual %0h required none", b_input);
                end else chk("b_data", b_input, exp_b.pop_front());
                hs_b++;
                if (first_hs_rel < 0) first_hs_rel = mrel;
                last_hs_rel = mrel;
            end
            if (mem_re) begin
                if (reads_a < cur_a_len && mem_addr == cur_a_base + AW'(reads_a)) begin
                    reads_a++; rd_s.push_back(0); rd_rel.push_back(mrel);
                end else if (reads_b < cur_b_len && mem_addr == cur_b_base + AW'(reads_b)) begin
                    reads_b++; rd_s.push_back(1); rd_rel.push_back(mrel);
                end else begin
                    checks++; errors++;
                    $display("FAIL mem_addr: actual %0h required a %0h or b %0h", mem_addr,
                             cur_a_base + AW'(reads_a), cur_b_base + AW'(reads_b));
                end
                chk("a_outstanding_le2", (reads_a - hs_a) <= 2, 1);
                chk("b_outstanding_le2", (reads_b - hs_b) <= 2, 1);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mem_re"}, mem_re, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_a_valid"}, a_valid, 0);
        chk({tag, "_b_valid"}, b_valid, 0);
        chk({tag, "_a_input"}, a_input, 0);
        chk({tag, "_b_input"}, b_input, 0);
`ifdef CONV_INPUT_STREAMER_STALL_CNT_EN
        chk({tag, "_stall_cycles"}, stall_cycles, 0);
`endif
    endtask

    task automatic start_xfer(input logic [AW-1:0] sab, input int sal,
                              input logic [AW-1:0] sbb, input int sbl, input int mode);
        logic [AW-1:0] idx;
        @(posedge clk);
        #1;
        a_base = sab; a_len = LW'(sal);
        b_base = sbb; b_len = LW'(sbl);
        start = 1'b1;
        ready_mode = mode;
        c0 = cyc;
        cur_a_base = sab; cur_a_len = sal;
        cur_b_base = sbb; cur_b_len = sbl;
        exp_a.delete(); exp_b.delete(); rd_rel.delete(); rd_s.delete();
        for (int i = 0; i < sal; i++) begin
            idx = sab + AW'(i);
            exp_a.push_back(mem[idx][DW-1:0]);
        end
        for (int i = 0; i < sbl; i++) begin
            idx = sbb + AW'(i);
            exp_b.push_back(mem[idx][DW-1:0]);
        end
        reads_a = 0; reads_b = 0; hs_a = 0; hs_b = 0;
        done_cnt = 0; done_rel = -1; busy_cnt = 0;
        first_hs_rel = -1; last_hs_rel = -1;
        b_valid_seen = 1'b0; a_stall_prev = 1'b0; b_stall_prev = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit got;
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(posedge clk);
            if (done_cnt > 0) got = 1'b1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_timeout: actual no done required done within %0d cycles", limit);
        end else begin
            chk("exp_a_empty", exp_a.size(), 0);
            chk("exp_b_empty", exp_b.size(), 0);
            chk("hs_a_count", hs_a, cur_a_len);
            chk("hs_b_count", hs_b, cur_b_len);
            chk("done_after_last_hs", done_rel, (hs_a + hs_b == 0) ? 2 : last_hs_rel + 1);
            chk("busy_cycles", busy_cnt, done_rel - 1);
            repeat (2) @(posedge clk);
            chk("done_one_cycle", done_cnt, 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[16 + i] = MW'(i + 1);

        rst_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_in = 1'b0;
        @(negedge clk);
        check_reset_vals("por");

        // single stream, full rate
        start_xfer(16'd16, 4, 16'h4000, 0, 0);
        wait_done(100);
        chk("t1_done_rel", done_rel, 7);
        chk("t1_first_hs", first_hs_rel, 3);
        chk("t1_b_never_valid", b_valid_seen, 0);

        // both streams, round-robin issue
        start_xfer(16'd200, 3, 16'd300, 3, 0);
        wait_done(100);
        chk("t2_done_rel", done_rel, 9);
        chk("t2_read_count", rd_s.size(), 6);
        for (int k = 0; k < 6 && k < rd_s.size(); k++) begin
            chk("t2_read_cycle", rd_rel[k], k + 1);
            chk("t2_read_stream", rd_s[k], k % 2);
        end

        // backpressure on a
        start_xfer(16'd400, 8, 16'h5000, 0, 2);
        wait_done(100);
`ifdef CONV_INPUT_STREAMER_STALL_CNT_EN
        chk("t3_stall_cycles", stall_cycles, 5);
`endif

        // both lengths zero
        start_xfer(16'd600, 0, 16'd700, 0, 0);
        wait_done(20);
        chk("t4_done_rel", done_rel, 2);
        chk("t4_busy_cycles", busy_cnt, 1);
        chk("t4_no_reads", rd_s.size(), 0);

        // reset mid-transfer
        start_xfer(16'd800, 10, 16'h6000, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        check_reset_vals("t5");
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_done", done, 0);
        end
        start_xfer(16'd900, 5, 16'd1000, 3, 0);
        wait_done(100);

        // start re-pulsed during RUN is ignored
        start_xfer(16'd40, 6, 16'd80, 5, 1);
        @(posedge clk);
        #1;
        a_base = 16'd1000; b_base = 16'd2000; a_len = 16'd3; b_len = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(200);

        // randomized transfers, first one wraps the address space
        for (int k = 0; k < 20; k++) begin
            ab = (k == 0) ? 16'hFFFE : AW'($urandom);
            bb = ab + 16'd100 + AW'($urandom_range(0, 1000));
            al = (k == 0) ? 5 : int'($urandom_range(0, 12));
            bl = int'($urandom_range(0, 12));
            start_xfer(ab, al, bb, bl, 1);
            wait_done(300);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
